// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM capture block.
// State encoding, synchronizer depth and the counter saturation helper.
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    HIGH      = 2'd1,
    LOW       = 2'd2
  } state_t;

  localparam int SYNC_STAGES = 2;

  function automatic logic [63:0] cnt_max(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/pwm_capture_if.sv
// Measurement result bundle of pwm_capture; master drives, slave observes.
// Results are qualified by a single-cycle valid strobe and held between strobes.
interface pwm_capture_if #(
  parameter int CNT_W = 16
);
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             valid;
  logic             ovf;
  logic             level;
  logic             locked;

  modport master (output high_cnt, period_cnt, valid, ovf, level, locked);
  modport slave  (input  high_cnt, period_cnt, valid, ovf, level, locked);
endinterface

// File: rtl/pwm_sync_edge.sv
// Async input synchronizer with optional glitch filter (PWM_CAPTURE_FILTER_EN) and edge detect.
// Edges are suppressed until the pipeline holds real samples, so no false edge follows reset.
module pwm_sync_edge
  import pwm_capture_pkg::*;
`ifdef PWM_CAPTURE_FILTER_EN
#(
  parameter int FILTER_LEN = 4
)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic s,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   sync_out;
  logic                   sync_ok;
  logic                   s_real;
  logic                   s_prev;
  logic                   armed;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign sync_ok  = fill_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      fill_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FCW = $clog2(FILTER_LEN + 1);

  logic           filt_q;
  logic           seeded_q;
  logic [FCW-1:0] run_q;

  // The filter is seeded from the first real sample rather than filtered from 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q   <= 1'b0;
      seeded_q <= 1'b0;
      run_q    <= '0;
    end else if (!seeded_q) begin
      if (sync_ok) begin
        filt_q   <= sync_out;
        seeded_q <= 1'b1;
      end
    end else if (sync_out == filt_q) begin
      run_q <= '0;
    end else if (run_q == FCW'(FILTER_LEN - 1)) begin
      filt_q <= sync_out;
      run_q  <= '0;
    end else begin
      run_q <= run_q + 1'b1;
    end
  end

  assign s      = filt_q;
  assign s_real = seeded_q;
`else
  assign s      = sync_out;
  assign s_real = sync_ok;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s_prev <= 1'b0;
      armed  <= 1'b0;
    end else begin
      s_prev <= s;
      armed  <= s_real;
    end
  end

  assign rise = armed &  s & ~s_prev;
  assign fall = armed & ~s &  s_prev;

endmodule

// File: rtl/pwm_capture.sv
// Measures PWM high time and period in clk cycles; one result per period, ovf on saturation.
// Optional glitch filter on the input path via PWM_CAPTURE_FILTER_EN.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int CNT_W = 16
`ifdef PWM_CAPTURE_FILTER_EN
  , parameter int FILTER_LEN = 4
`endif
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pwm_in,
  pwm_capture_if.master  res
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic             s;
  logic             rise;
  logic             fall;

  state_t           state_q, state_nx;
  logic [CNT_W-1:0] hc_q, hc_nx;
  logic [CNT_W-1:0] pc_q, pc_nx;
  logic [CNT_W-1:0] high_q, high_nx;
  logic [CNT_W-1:0] period_q, period_nx;
  logic             valid_q, valid_nx;
  logic             ovf_q, ovf_nx;
  logic             locked_q, locked_nx;

  pwm_sync_edge
`ifdef PWM_CAPTURE_FILTER_EN
  #(.FILTER_LEN(FILTER_LEN))
`endif
  u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (pwm_in),
    .s    (s),
    .rise (rise),
    .fall (fall)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= WAIT_RISE;
      hc_q     <= '0;
      pc_q     <= '0;
      high_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_nx;
      hc_q     <= hc_nx;
      pc_q     <= pc_nx;
      high_q   <= high_nx;
      period_q <= period_nx;
      valid_q  <= valid_nx;
      ovf_q    <= ovf_nx;
      locked_q <= locked_nx;
    end
  end

  always_comb begin
    state_nx  = state_q;
    hc_nx     = hc_q;
    pc_nx     = pc_q;
    high_nx   = high_q;
    period_nx = period_q;
    valid_nx  = 1'b0;
    ovf_nx    = ovf_q;
    locked_nx = locked_q;

    unique case (state_q)
      WAIT_RISE: begin
        if (rise) begin
          hc_nx    = ONE;
          pc_nx    = ONE;
          state_nx = HIGH;
        end
      end
      HIGH: begin
        if (pc_q == MAX) begin
          valid_nx  = 1'b1;
          ovf_nx    = 1'b1;
          high_nx   = hc_q;
          period_nx = MAX;
          locked_nx = 1'b0;
          state_nx  = WAIT_RISE;
        end else begin
          pc_nx = pc_q + 1'b1;
          if (fall) state_nx = LOW;
          else      hc_nx    = hc_q + 1'b1;
        end
      end
      LOW: begin
        // A rise wins over saturation, and restarts counting with no dead cycle.
        if (rise) begin
          valid_nx  = 1'b1;
          ovf_nx    = 1'b0;
          high_nx   = hc_q;
          period_nx = pc_q;
          locked_nx = 1'b1;
          hc_nx     = ONE;
          pc_nx     = ONE;
          state_nx  = HIGH;
        end else if (pc_q == MAX) begin
          valid_nx  = 1'b1;
          ovf_nx    = 1'b1;
          high_nx   = hc_q;
          period_nx = MAX;
          locked_nx = 1'b0;
          state_nx  = WAIT_RISE;
        end else begin
          pc_nx = pc_q + 1'b1;
        end
      end
      default: state_nx = WAIT_RISE;
    endcase
  end

  assign res.high_cnt   = high_q;
  assign res.period_cnt = period_q;
  assign res.valid      = valid_q;
  assign res.ovf        = ovf_q;
  assign res.locked     = locked_q;
  assign res.level      = s;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture at CNT_W=8: table-driven waveforms plus corner sequences.
module tb_pwm_capture;

  typedef struct {
    logic [7:0] hc;
    logic [7:0] pc;
    logic       ovf;
    logic       locked;
    logic       level;
    int         cyc;
  } strobe_t;

  typedef struct {
    int   high;
    int   low;
    int   n;
    int   exp_hc;
    int   exp_pc;
    logic exp_ovf;
    logic exp_locked;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pwm_in = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  strobe_t strb[$];

  pwm_capture_if #(.CNT_W(8)) res_if ();

  pwm_capture #(.CNT_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (pwm_in),
    .res    (res_if)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (!rst && res_if.valid === 1'b1)
      strb.push_back('{res_if.high_cnt, res_if.period_cnt, res_if.ovf,
                       res_if.locked, res_if.level, cyc});
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input logic pwm_level);
    @(negedge clk);
    rst    = 1'b1;
    pwm_in = pwm_level;
    cycles(3);
    rst = 1'b0;
    strb.delete();
  endtask

  // Lead-in low, n full periods, then a closing rise held high.
  task automatic run_wave(input int lead, input int h, input int l, input int n);
    pwm_in = 1'b0;
    cycles(lead);
    for (int k = 0; k < n; k++) begin
      pwm_in = 1'b1;
      cycles(h);
      pwm_in = 1'b0;
      cycles(l);
    end
    pwm_in = 1'b1;
    cycles(12);
  endtask

  vec_t vecs[5];
  int   g_hc[$];
  int   g_pc[$];

  initial begin
    vecs[0] = '{3,   5,   4, 3,   8,   1'b0, 1'b1};
    vecs[1] = '{16,  16,  3, 16,  32,  1'b0, 1'b1};
    vecs[2] = '{6,   5,   3, 6,   11,  1'b0, 1'b1};
    vecs[3] = '{100, 155, 2, 100, 255, 1'b0, 1'b1};
    vecs[4] = '{100, 156, 2, 100, 255, 1'b1, 1'b0};

    // Reset state
    rst = 1'b1;
    pwm_in = 1'b0;
    cycles(3);
    chk("rst_high_cnt",   32'(res_if.high_cnt),   0);
    chk("rst_period_cnt", 32'(res_if.period_cnt), 0);
    chk("rst_valid",      32'(res_if.valid),      0);
    chk("rst_ovf",        32'(res_if.ovf),        0);
    chk("rst_level",      32'(res_if.level),      0);
    chk("rst_locked",     32'(res_if.locked),     0);

    // Table-driven periodic waveforms
    for (int i = 0; i < 5; i++) begin
      do_reset(1'b0);
      run_wave(10, vecs[i].high, vecs[i].low, vecs[i].n);
      chk($sformatf("v%0d_count", i), 32'(strb.size()), 32'(vecs[i].n));
      for (int k = 0; k < strb.size(); k++) begin
        chk($sformatf("v%0d_s%0d_hc", i, k),  32'(strb[k].hc),     32'(vecs[i].exp_hc));
        chk($sformatf("v%0d_s%0d_pc", i, k),  32'(strb[k].pc),     32'(vecs[i].exp_pc));
        chk($sformatf("v%0d_s%0d_ovf", i, k), 32'(strb[k].ovf),    32'(vecs[i].exp_ovf));
        chk($sformatf("v%0d_s%0d_lck", i, k), 32'(strb[k].locked), 32'(vecs[i].exp_locked));
        if (k > 0)
          chk($sformatf("v%0d_s%0d_gap", i, k), 32'(strb[k].cyc - strb[k-1].cyc),
              32'(vecs[i].high + vecs[i].low));
      end
    end

    // Reset released mid-pulse: partial pulse is ignored
    do_reset(1'b1);
    cycles(7);
    run_wave(16, 16, 16, 2);
    chk("midhigh_count", 32'(strb.size()), 2);
    if (strb.size() > 0) begin
      chk("midhigh_hc", 32'(strb[0].hc), 16);
      chk("midhigh_pc", 32'(strb[0].pc), 32);
    end

    // Stuck high
    do_reset(1'b0);
    cycles(10);
    pwm_in = 1'b1;
    cycles(300);
    chk("stuckhi_count", 32'(strb.size()), 1);
    if (strb.size() > 0) begin
      chk("stuckhi_ovf",   32'(strb[0].ovf),    1);
      chk("stuckhi_hc",    32'(strb[0].hc),     255);
      chk("stuckhi_pc",    32'(strb[0].pc),     255);
      chk("stuckhi_lck",   32'(strb[0].locked), 0);
      chk("stuckhi_level", 32'(strb[0].level),  1);
    end
    chk("stuckhi_level_now", 32'(res_if.level), 1);

    // Held low after one pulse
    do_reset(1'b0);
    cycles(10);
    pwm_in = 1'b1; cycles(5);
    pwm_in = 1'b0; cycles(5);
    pwm_in = 1'b1; cycles(5);
    pwm_in = 1'b0; cycles(300);
    chk("stucklo_count", 32'(strb.size()), 2);
    if (strb.size() > 1) begin
      chk("stucklo_s0_pc",  32'(strb[0].pc),     10);
      chk("stucklo_s0_lck", 32'(strb[0].locked), 1);
      chk("stucklo_ovf",    32'(strb[1].ovf),    1);
      chk("stucklo_hc",     32'(strb[1].hc),     5);
      chk("stucklo_pc",     32'(strb[1].pc),     255);
      chk("stucklo_lck",    32'(strb[1].locked), 0);
    end
    chk("stucklo_locked_now", 32'(res_if.locked), 0);

    // One-cycle reset in the middle of a low phase
    do_reset(1'b0);
    cycles(10);
    pwm_in = 1'b1; cycles(4);
    pwm_in = 1'b0; cycles(6);
    pwm_in = 1'b1; cycles(4);
    pwm_in = 1'b0; cycles(9);
    chk("midrst_pre_count", 32'(strb.size()), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_high_cnt",   32'(res_if.high_cnt),   0);
    chk("midrst_period_cnt", 32'(res_if.period_cnt), 0);
    chk("midrst_valid",      32'(res_if.valid),      0);
    chk("midrst_ovf",        32'(res_if.ovf),        0);
    chk("midrst_locked",     32'(res_if.locked),     0);
    strb.delete();
    run_wave(10, 4, 6, 2);
    chk("midrst_count", 32'(strb.size()), 2);
    for (int k = 0; k < strb.size(); k++) begin
      chk($sformatf("midrst_s%0d_hc", k), 32'(strb[k].hc), 4);
      chk($sformatf("midrst_s%0d_pc", k), 32'(strb[k].pc), 10);
    end

    // Two-cycle glitch inside a 10/10 waveform
`ifdef PWM_CAPTURE_FILTER_EN
    g_hc = '{10, 10, 10};
    g_pc = '{20, 20, 20};
`else
    g_hc = '{10, 4, 4, 10};
    g_pc = '{20, 6, 14, 20};
`endif
    do_reset(1'b0);
    cycles(10);
    pwm_in = 1'b1; cycles(10);
    pwm_in = 1'b0; cycles(10);
    pwm_in = 1'b1; cycles(4);
    pwm_in = 1'b0; cycles(2);
    pwm_in = 1'b1; cycles(4);
    pwm_in = 1'b0; cycles(10);
    run_wave(0, 10, 10, 1);
    chk("glitch_count", 32'(strb.size()), 32'(g_hc.size()));
    for (int k = 0; k < strb.size() && k < g_hc.size(); k++) begin
      chk($sformatf("glitch_s%0d_hc", k), 32'(strb[k].hc), 32'(g_hc[k]));
      chk($sformatf("glitch_s%0d_pc", k), 32'(strb[k].pc), 32'(g_pc[k]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
